inv_sbytes_seq: RTL and testbench
=================================

// Module: inv_sbytes_seq
// PURPOSE
//  Iterative InvSubBytes engine for the AES-128 decrypt datapath; the inverse of the
//  encrypt-side SubBytes stage. Accepts a 128-bit state on a valid/ready handshake.
//  Applies the FIPS-197 inverse S-box to BPC bytes per cycle, shared across all state bytes.
//  Presents the substituted state on a valid/ready output handshake to the next decrypt stage.
// PARAMETERS
//  NWords  4  32-bit words in the state; state width = 32*NWords (128 for AES)
//  BPC     4  bytes substituted per clock; legal 1,2,4,8,16; must divide 4*NWords
// PORTS
//  clk        in   1            rising-edge clock, sole clock domain
//  rst_n      in   1            synchronous active-low reset, sampled on rising clk
//  in_valid   in   1            state_in valid
//  in_ready   out  1            engine can accept a state
//  state_in   in   32*NWords    ciphertext-side state; byte 0 = [MSB:MSB-7]
//  out_valid  out  1            state_out holds a complete result
//  out_ready  in   1            downstream accepts state_out
//  state_out  out  32*NWords    InvSubBytes(state_in), byte order preserved
// BEHAVIOUR
//  - NB = 4*NWords; NSTEP = NB/BPC (4 at defaults). Byte k = state[8*(NB-k)-1 -: 8].
//  - Reset (rst_n=0 at clk edge): FSM=IDLE, step counter=0, in_ready=1, out_valid=0,
//    state_out=0. Reset overrides every other event, including mid-BUSY and mid-DONE;
//    the in-flight state is discarded and no out_valid pulse is produced.
//  - FSM IDLE: in_ready=1. On in_valid&&in_ready, capture state_in into the work
//    register, counter=0, go BUSY.
//  - FSM BUSY: in_ready=0. Each cycle, replace bytes [counter*BPC .. counter*BPC+BPC-1]
//    with InvSbox(byte). Increment the counter. After step NSTEP-1, go DONE.
//  - FSM DONE: out_valid=1, state_out=work register, held stable until out_ready=1.
//    On out_valid&&out_ready: out_valid=0 next cycle, go IDLE. in_ready stays 0 in DONE.
//  - Latency: accept edge -> out_valid high after exactly NSTEP+1 edges (5 at defaults).
//    Throughput: one state per NSTEP+2 cycles when out_ready is held high.
//  - in_valid while BUSY or DONE is ignored; state_in is a don't-care then.
//  - out_ready while out_valid=0 is ignored.
//  - The counter is sized clog2(NSTEP) (min 1 bit) and is cleared on entry to BUSY, never
//    wrapped mid-op. The inverse S-box is a combinational 256-entry case ROM, replicated BPC times.
//  - state_out reflects only completed results. Partial work is never visible; the work register is internal.
// TESTING
//  1 FIPS-197 vector: state_in=d42711aee0bf98f1b8b45de51e415230, out_ready=1 ->
//    state_out=193de3bea0f4e22b9ac68d2ae9f84808, out_valid exactly 5 edges after accept.
//  2 S-box corners: state_in bytes 00,63,d4,27,.. -> 52,00,19,3d,..; all 256 values swept
//    over 16 states, each checked against the inverse S-box table.
//  3 Backpressure: out_ready=0 for 10 cycles after done -> out_valid and state_out held
//    constant, in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0, in_ready=1.
//  4 Reset mid-op: rst_n=0 at BUSY step 2 -> next edge out_valid=0, state_out=0, in_ready=1.
//    A new vector then completes correctly, with no residue from the aborted state.
//  5 Handshake abuse: in_valid toggling with a different state during BUSY/DONE -> result
//    equals InvSubBytes of the originally accepted state only.
//  6 Round-trip: random 128-bit X through encrypt SubBytes (NWords=4), then this block
//    with BPC=1,2,16 -> output == X; latency 17, 9, 2 edges respectively.

Source files
------------

// File: rtl/inv_sbytes_seq.sv
// rtl/inv_sbytes_seq.sv - iterative AES InvSubBytes engine, BPC bytes substituted per clock
module inv_sbytes_seq #(
    parameter int NWords = 4,
    parameter int BPC    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*NWords-1:0]  state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NWords-1:0]  state_out
);
    localparam int SW    = 32 * NWords;
    localparam int NB    = 4 * NWords;
    localparam int NSTEP = NB / BPC;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t          fsm;
    logic [CW-1:0] cnt;
    logic [SW-1:0] work;
    logic [SW-1:0] work_sub;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        inv_sbox = 8'h00;
        case (b)
            8'h00: inv_sbox = 8'h52; 8'h01: inv_sbox = 8'h09; 8'h02: inv_sbox = 8'h6a; 8'h03: inv_sbox = 8'hd5; 8'h04: inv_sbox = 8'h30; 8'h05: inv_sbox = 8'h36; 8'h06: inv_sbox = 8'ha5; 8'h07: inv_sbox = 8'h38;
            8'h08: inv_sbox = 8'hbf; 8'h09: inv_sbox = 8'h40; 8'h0a: inv_sbox = 8'ha3; 8'h0b: inv_sbox = 8'h9e; 8'h0c: inv_sbox = 8'h81; 8'h0d: inv_sbox = 8'hf3; 8'h0e: inv_sbox = 8'hd7; 8'h0f: inv_sbox = 8'hfb;
            8'h10: inv_sbox = 8'h7c; 8'h11: inv_sbox = 8'he3; 8'h12: inv_sbox = 8'h39; 8'h13: inv_sbox = 8'h82; 8'h14: inv_sbox = 8'h9b; 8'h15: inv_sbox = 8'h2f; 8'h16: inv_sbox = 8'hff; 8'h17: inv_sbox = 8'h87;
            8'h18: inv_sbox = 8'h34; 8'h19: inv_sbox = 8'h8e; 8'h1a: inv_sbox = 8'h43; 8'h1b: inv_sbox = 8'h44; 8'h1c: inv_sbox = 8'hc4; 8'h1d: inv_sbox = 8'hde; 8'h1e: inv_sbox = 8'he9; 8'h1f: inv_sbox = 8'hcb;
            8'h20: inv_sbox = 8'h54; 8'h21: inv_sbox = 8'h7b; 8'h22: inv_sbox = 8'h94; 8'h23: inv_sbox = 8'h32; 8'h24: inv_sbox = 8'ha6; 8'h25: inv_sbox = 8'hc2; 8'h26: inv_sbox = 8'h23; 8'h27: inv_sbox = 8'h3d;
            8'h28: inv_sbox = 8'hee; 8'h29: inv_sbox = 8'h4c; 8'h2a: inv_sbox = 8'h95; 8'h2b: inv_sbox = 8'h0b; 8'h2c: inv_sbox = 8'h42; 8'h2d: inv_sbox = 8'hfa; 8'h2e: inv_sbox = 8'hc3; 8'h2f: inv_sbox = 8'h4e;
            8'h30: inv_sbox = 8'h08; 8'h31: inv_sbox = 8'h2e; 8'h32: inv_sbox = 8'ha1; 8'h33: inv_sbox = 8'h66; 8'h34: inv_sbox = 8'h28; 8'h35: inv_sbox = 8'hd9; 8'h36: inv_sbox = 8'h24; 8'h37: inv_sbox = 8'hb2;
            8'h38: inv_sbox = 8'h76; 8'h39: inv_sbox = 8'h5b; 8'h3a: inv_sbox = 8'ha2; 8'h3b: inv_sbox = 8'h49; 8'h3c: inv_sbox = 8'h6d; 8'h3d: inv_sbox = 8'h8b; 8'h3e: inv_sbox = 8'hd1; 8'h3f: inv_sbox = 8'h25;
            8'h40: inv_sbox = 8'h72; 8'h41: inv_sbox = 8'hf8; 8'h42: inv_sbox = 8'hf6; 8'h43: inv_sbox = 8'h64; 8'h44: inv_sbox = 8'h86; 8'h45: inv_sbox = 8'h68; 8'h46: inv_sbox = 8'h98; 8'h47: inv_sbox = 8'h16;
            8'h48: inv_sbox = 8'hd4; 8'h49: inv_sbox = 8'ha4; 8'h4a: inv_sbox = 8'h5c; 8'h4b: inv_sbox = 8'hcc; 8'h4c: inv_sbox = 8'h5d; 8'h4d: inv_sbox = 8'h65; 8'h4e: inv_sbox = 8'hb6; 8'h4f: inv_sbox = 8'h92;
            8'h50: inv_sbox = 8'h6c; 8'h51: inv_sbox = 8'h70; 8'h52: inv_sbox = 8'h48; 8'h53: inv_sbox = 8'h50; 8'h54: inv_sbox = 8'hfd; 8'h55: inv_sbox = 8'hed; 8'h56: inv_sbox = 8'hb9; 8'h57: inv_sbox = 8'hda;
            8'h58: inv_sbox = 8'h5e; 8'h59: inv_sbox = 8'h15; 8'h5a: inv_sbox = 8'h46; 8'h5b: inv_sbox = 8'h57; 8'h5c: inv_sbox = 8'ha7; 8'h5d: inv_sbox = 8'h8d; 8'h5e: inv_sbox = 8'h9d; 8'h5f: inv_sbox = 8'h84;
            8'h60: inv_sbox = 8'h90; 8'h61: inv_sbox = 8'hd8; 8'h62: inv_sbox = 8'hab; 8'h63: inv_sbox = 8'h00; 8'h64: inv_sbox = 8'h8c; 8'h65: inv_sbox = 8'hbc; 8'h66: inv_sbox = 8'hd3; 8'h67: inv_sbox = 8'h0a;
            8'h68: inv_sbox = 8'hf7; 8'h69: inv_sbox = 8'he4; 8'h6a: inv_sbox = 8'h58; 8'h6b: inv_sbox = 8'h05; 8'h6c: inv_sbox = 8'hb8; 8'h6d: inv_sbox = 8'hb3; 8'h6e: inv_sbox = 8'h45; 8'h6f: inv_sbox = 8'h06;
            8'h70: inv_sbox = 8'hd0; 8'h71: inv_sbox = 8'h2c; 8'h72: inv_sbox = 8'h1e; 8'h73: inv_sbox = 8'h8f; 8'h74: inv_sbox = 8'hca; 8'h75: inv_sbox = 8'h3f; 8'h76: inv_sbox = 8'h0f; 8'h77: inv_sbox = 8'h02;
            8'h78: inv_sbox = 8'hc1; 8'h79: inv_sbox = 8'haf; 8'h7a: inv_sbox = 8'hbd; 8'h7b: inv_sbox = 8'h03; 8'h7c: inv_sbox = 8'h01; 8'h7d: inv_sbox = 8'h13; 8'h7e: inv_sbox = 8'h8a; 8'h7f: inv_sbox = 8'h6b;
            8'h80: inv_sbox = 8'h3a; 8'h81: inv_sbox = 8'h91; 8'h82: inv_sbox = 8'h11; 8'h83: inv_sbox = 8'h41; 8'h84: inv_sbox = 8'h4f; 8'h85: inv_sbox = 8'h67; 8'h86: inv_sbox = 8'hdc; 8'h87: inv_sbox = 8'hea;
            8'h88: inv_sbox = 8'h97; 8'h89: inv_sbox = 8'hf2; 8'h8a: inv_sbox = 8'hcf; 8'h8b: inv_sbox = 8'hce; 8'h8c: inv_sbox = 8'hf0; 8'h8d: inv_sbox = 8'hb4; 8'h8e: inv_sbox = 8'he6; 8'h8f: inv_sbox = 8'h73;
            8'h90: inv_sbox = 8'h96; 8'h91: inv_sbox = 8'hac; 8'h92: inv_sbox = 8'h74; 8'h93: inv_sbox = 8'h22; 8'h94: inv_sbox = 8'he7; 8'h95: inv_sbox = 8'had; 8'h96: inv_sbox = 8'h35; 8'h97: inv_sbox = 8'h85;
            8'h98: inv_sbox = 8'he2; 8'h99: inv_sbox = 8'hf9; 8'h9a: inv_sbox = 8'h37; 8'h9b: inv_sbox = 8'he8; 8'h9c: inv_sbox = 8'h1c; 8'h9d: inv_sbox = 8'h75; 8'h9e: inv_sbox = 8'hdf; 8'h9f: inv_sbox = 8'h6e;
            8'ha0: inv_sbox = 8'h47; 8'ha1: inv_sbox = 8'hf1; 8'ha2: inv_sbox = 8'h1a; 8'ha3: inv_sbox = 8'h71; 8'ha4: inv_sbox = 8'h1d; 8'ha5: inv_sbox = 8'h29; 8'ha6: inv_sbox = 8'hc5; 8'ha7: inv_sbox = 8'h89;
            8'ha8: inv_sbox = 8'h6f; 8'ha9: inv_sbox = 8'hb7; 8'haa: inv_sbox = 8'h62; 8'hab: inv_sbox = 8'h0e; 8'hac: inv_sbox = 8'haa; 8'had: inv_sbox = 8'h18; 8'hae: inv_sbox = 8'hbe; 8'haf: inv_sbox = 8'h1b;
            8'hb0: inv_sbox = 8'hfc; 8'hb1: inv_sbox = 8'h56; 8'hb2: inv_sbox = 8'h3e; 8'hb3: inv_sbox = 8'h4b; 8'hb4: inv_sbox = 8'hc6; 8'hb5: inv_sbox = 8'hd2; 8'hb6: inv_sbox = 8'h79; 8'hb7: inv_sbox = 8'h20;
            8'hb8: inv_sbox = 8'h9a; 8'hb9: inv_sbox = 8'hdb; 8'hba: inv_sbox = 8'hc0; 8'hbb: inv_sbox = 8'hfe; 8'hbc: inv_sbox = 8'h78; 8'hbd: inv_sbox = 8'hcd; 8'hbe: inv_sbox = 8'h5a; 8'hbf: inv_sbox = 8'hf4;
            8'hc0: inv_sbox = 8'h1f; 8'hc1: inv_sbox = 8'hdd; 8'hc2: inv_sbox = 8'ha8; 8'hc3: inv_sbox = 8'h33; 8'hc4: inv_sbox = 8'h88; 8'hc5: inv_sbox = 8'h07; 8'hc6: inv_sbox = 8'hc7; 8'hc7: inv_sbox = 8'h31;
            8'hc8: inv_sbox = 8'hb1; 8'hc9: inv_sbox = 8'h12; 8'hca: inv_sbox = 8'h10; 8'hcb: inv_sbox = 8'h59; 8'hcc: inv_sbox = 8'h27; 8'hcd: inv_sbox = 8'h80; 8'hce: inv_sbox = 8'hec; 8'hcf: inv_sbox = 8'h5f;
            8'hd0: inv_sbox = 8'h60; 8'hd1: inv_sbox = 8'h51; 8'hd2: inv_sbox = 8'h7f; 8'hd3: inv_sbox = 8'ha9; 8'hd4: inv_sbox = 8'h19; 8'hd5: inv_sbox = 8'hb5; 8'hd6: inv_sbox = 8'h4a; 8'hd7: inv_sbox = 8'h0d;
            8'hd8: inv_sbox = 8'h2d; 8'hd9: inv_sbox = 8'he5; 8'hda: inv_sbox = 8'h7a; 8'hdb: inv_sbox = 8'h9f; 8'hdc: inv_sbox = 8'h93; 8'hdd: inv_sbox = 8'hc9; 8'hde: inv_sbox = 8'h9c; 8'hdf: inv_sbox = 8'hef;
            8'he0: inv_sbox = 8'ha0; 8'he1: inv_sbox = 8'he0; 8'he2: inv_sbox = 8'h3b; 8'he3: inv_sbox = 8'h4d; 8'he4: inv_sbox = 8'hae; 8'he5: inv_sbox = 8'h2a; 8'he6: inv_sbox = 8'hf5; 8'he7: inv_sbox = 8'hb0;
            8'he8: inv_sbox = 8'hc8; 8'he9: inv_sbox = 8'heb; 8'hea: inv_sbox = 8'hbb; 8'heb: inv_sbox = 8'h3c; 8'hec: inv_sbox = 8'h83; 8'hed: inv_sbox = 8'h53; 8'hee: inv_sbox = 8'h99; 8'hef: inv_sbox = 8'h61;
            8'hf0: inv_sbox = 8'h17; 8'hf1: inv_sbox = 8'h2b; 8'hf2: inv_sbox = 8'h04; 8'hf3: inv_sbox = 8'h7e; 8'hf4: inv_sbox = 8'hba; 8'hf5: inv_sbox = 8'h77; 8'hf6: inv_sbox = 8'hd6; 8'hf7: inv_sbox = 8'h26;
            8'hf8: inv_sbox = 8'he1; 8'hf9: inv_sbox = 8'h69; 8'hfa: inv_sbox = 8'h14; 8'hfb: inv_sbox = 8'h63; 8'hfc: inv_sbox = 8'h55; 8'hfd: inv_sbox = 8'h21; 8'hfe: inv_sbox = 8'h0c; 8'hff: inv_sbox = 8'h7d;
        endcase
    endfunction

    // One ROM per lane; the step counter selects which BPC-byte slice the lanes see.
    always_comb begin
        work_sub = work;
        for (int j = 0; j < BPC; j++) begin
            work_sub[SW-1-8*(int'(cnt)*BPC+j) -: 8] = inv_sbox(work[SW-1-8*(int'(cnt)*BPC+j) -: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state_out <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= state_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        fsm      <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_sub;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state_out <= work_sub;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sbytes_seq.sv
// tb/tb_inv_sbytes_seq.sv - scoreboard bench for inv_sbytes_seq at BPC=4,1,2,16
module tb_inv_sbytes_seq;
    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] state_in  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] state_out [NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from GF(2^8) inversion plus affine map; inverse table by inversion.
    task automatic build_tables();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] gi;
            logic [7:0] s;
            gi = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) gi = 8'(y);
            s = gi ^ {gi[6:0], gi[7]} ^ {gi[5:0], gi[7:6]} ^ {gi[4:0], gi[7:5]} ^ {gi[3:0], gi[7:4]} ^ 8'h63;
            fwd_tab[v] = s;
            inv_tab[s] = 8'(v);
        end
    endtask

    function automatic logic [127:0] map_bytes(input logic [127:0] s, input bit inverse);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[127-8*k -: 8] = inverse ? inv_tab[s[127-8*k -: 8]] : fwd_tab[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int B   = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
        localparam int LAT = 16 / B + 1;

        inv_sbytes_seq #(.NWords(4), .BPC(B)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .state_in(state_in[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .state_out(state_out[g])
        );

        initial begin
            int acc_cyc;
            bit acc_pend;
            bit holding;
            bit drop_chk;
            logic [127:0] held;
            logic [127:0] e;
            acc_cyc = 0; acc_pend = 0; holding = 0; drop_chk = 0; held = '0; e = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    acc_pend = 0; holding = 0; drop_chk = 0;
                end else begin
                    if (drop_chk) begin
                        chk(!out_valid[g] && in_ready[g], $sformatf("release[%0d]", g),
                            {out_valid[g], in_ready[g]}, 2'b01);
                        drop_chk = 0;
                    end
                    if (out_valid[g]) begin
                        if (!holding) begin
                            chk(acc_pend && (cyc - acc_cyc == LAT), $sformatf("latency[%0d]", g),
                                128'(cyc - acc_cyc), 128'(LAT));
                            if (exp_q[g].size() == 0) begin
                                chk(0, $sformatf("unexpected_out[%0d]", g), state_out[g], '0);
                            end else begin
                                e = exp_q[g].pop_front();
                                chk(state_out[g] === e, $sformatf("data[%0d]", g), state_out[g], e);
                            end
                            holding = 1;
                            held = state_out[g];
                            acc_pend = 0;
                        end else begin
                            chk(state_out[g] === held, $sformatf("hold_data[%0d]", g), state_out[g], held);
                        end
                        chk(in_ready[g] === 1'b0, $sformatf("in_ready_done[%0d]", g), in_ready[g], 0);
                        if (out_ready[g]) begin
                            holding = 0;
                            drop_chk = 1;
                        end
                    end
                    if (in_valid[g] && in_ready[g]) begin
                        acc_cyc = cyc;
                        acc_pend = 1;
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [127:0] d, input logic [127:0] e);
        int n;
        n = 0;
        in_valid[i] = 1'b1;
        state_in[i] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[i] && n < 400);
        if (!in_ready[i]) begin
            chk(0, "accept_timeout", 128'(i), '0);
            in_valid[i] = 1'b0;
        end else begin
            exp_q[i].push_back(e);
            @(posedge clk);
            #1 in_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int i, input bit rnd);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready[i] = ($urandom_range(0, 3) != 0);
            done = (exp_q[i].size() == 0) && in_ready[i] && !out_valid[i];
            n++;
        end
        out_ready[i] = 1'b1;
        if (!done) chk(0, "idle_timeout", 128'(i), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            state_in[i] = '0;
            out_ready[i] = 1'b1;
        end
        build_tables();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk(in_ready[i] === 1'b1 && out_valid[i] === 1'b0 && state_out[i] === '0, "reset_state",
                {out_valid[i], in_ready[i], state_out[i][15:0]}, {2'b01, 16'h0000});
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        wait_idle(0, 0);

        x = 128'h0063d42752097cff01108090a0b0c0e0;
        send(0, x, map_bytes(x, 1));
        wait_idle(0, 0);
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) x[127-8*k -: 8] = 8'(j * 16 + k);
            send(0, x, map_bytes(x, 1));
            wait_idle(0, 1);
        end

        out_ready[0] = 1'b0;
        x = rand128();
        send(0, x, map_bytes(x, 1));
        repeat (15) @(posedge clk);
        #1 out_ready[0] = 1'b1;
        wait_idle(0, 0);

        out_ready[0] = 1'b0;
        x = rand128();
        send(0, x, map_bytes(x, 1));
        for (int c = 0; c < 12; c++) begin
            in_valid[0] = 1'($urandom_range(0, 1));
            state_in[0] = rand128();
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        wait_idle(0, 0);

        x = rand128();
        send(0, x, map_bytes(x, 1));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(out_valid[0] === 1'b0 && in_ready[0] === 1'b1 && state_out[0] === '0, "reset_midop",
            {out_valid[0], in_ready[0], state_out[0][15:0]}, {2'b01, 16'h0000});
        exp_q[0].delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        x = rand128();
        send(0, x, map_bytes(x, 1));
        wait_idle(0, 0);

        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 4; n++) begin
                x = rand128();
                send(i, map_bytes(x, 0), x);
                wait_idle(i, 1);
            end
        end

        for (int n = 0; n < 10; n++) begin
            x = rand128();
            send(0, x, map_bytes(x, 1));
            wait_idle(0, 1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
